// File: rtl/parity_check_monitor.sv
// parity_check_monitor
//   Multi-channel parity checker/generator for a protected interface.
//   Each channel's data is split into GRAN_W-bit granules (the last one may
//   be partial). One parity bit is generated per granule and compared with
//   the parity received alongside the data. Mismatches are reported to the
//   fault collector through these outputs:
//     - sticky per-channel status
//     - a first-error capture record (channel and syndrome)
//     - a saturating count of error cycles
//     - a complementary registered error pair
//
// Ports
//   ACLK, RESETN_ACLK : clock, asynchronous active-low reset
//   I_DATA            : NUM_CH*DATA_W data, channel c at [c*DATA_W +: DATA_W]
//   I_PARITY          : NUM_CH*PAR_W received parity, channel c at [c*PAR_W +: PAR_W]
//   I_VALID           : per-channel qualifier
//   I_ENERR           : enables O_ERR/O_ERR_B (other state updates regardless)
//   I_FIERR           : fault-inject level; each rising edge injects one error
//   I_CLR             : one-cycle clear of status, capture and counter
//   O_GEN_PARITY      : combinational generated parity, zero when not valid
//   O_ERR, O_ERR_B    : registered error flag and its complement
//   O_ERR_STATUS      : sticky per-channel mismatch flags
//   O_FIRST_CH        : lowest mismatching channel of the first error event
//   O_FIRST_SYN       : syndrome (received ^ expected) of that channel
//   O_ERR_CNT         : saturating count of cycles with any mismatch
//   O_CNT_SAT         : counter is at all-ones
module parity_check_monitor #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 64,
  parameter int GRAN_W     = 8,
  parameter int ODD_PARITY = 0,
  parameter int CNT_W      = 8,
  parameter int CH_IDX_W   = 2,
  localparam int PAR_W     = (DATA_W + GRAN_W - 1) / GRAN_W
) (
  input  logic                     ACLK,
  input  logic                     RESETN_ACLK,
  input  logic [NUM_CH*DATA_W-1:0] I_DATA,
  input  logic [NUM_CH*PAR_W-1:0]  I_PARITY,
  input  logic [NUM_CH-1:0]        I_VALID,
  input  logic                     I_ENERR,
  input  logic                     I_FIERR,
  input  logic                     I_CLR,
  output logic [NUM_CH*PAR_W-1:0]  O_GEN_PARITY,
  output logic                     O_ERR,
  output logic                     O_ERR_B,
  output logic [NUM_CH-1:0]        O_ERR_STATUS,
  output logic [CH_IDX_W-1:0]      O_FIRST_CH,
  output logic [PAR_W-1:0]         O_FIRST_SYN,
  output logic [CNT_W-1:0]         O_ERR_CNT,
  output logic                     O_CNT_SAT
);

  typedef enum logic {ST_OK, ST_LATCHED} state_t;

  // Packed [channel][granule] views line up with the flat port layout.
  logic [NUM_CH-1:0][PAR_W-1:0] raw_par;
  logic [NUM_CH-1:0][PAR_W-1:0] rcv_par;
  logic [NUM_CH-1:0][PAR_W-1:0] gen_gated;
  logic [NUM_CH-1:0][PAR_W-1:0] rcv_gated;
  logic [NUM_CH-1:0][PAR_W-1:0] syn_s1_next;

  // Stage 1 registers.
  logic [NUM_CH-1:0]            valid_s1_reg;
  logic [NUM_CH-1:0][PAR_W-1:0] gen_s1_reg;
  logic [NUM_CH-1:0][PAR_W-1:0] rcv_s1_reg;
  logic                         fierr_q_reg;
  logic                         inj_s1_reg;

  // Stage 2 register.
  logic [NUM_CH-1:0][PAR_W-1:0] syn_s2_reg;

  // Status and reporting state.
  state_t                       state_reg;
  state_t                       state_next;
  logic                         err_reg;
  logic                         err_b_reg;
  logic [NUM_CH-1:0]            status_reg;
  logic [CH_IDX_W-1:0]          first_ch_reg;
  logic [PAR_W-1:0]             first_syn_reg;
  logic [CNT_W-1:0]             cnt_reg;

  logic [NUM_CH-1:0]            mis;
  logic                         ev;
  logic [CH_IDX_W-1:0]          first_ch_next;
  logic [PAR_W-1:0]             first_syn_next;
  logic                         cnt_sat;

  assign rcv_par = I_PARITY;

  // Granule parity: bit b of a channel folds into granule b/GRAN_W, so a
  // partial last granule simply receives fewer bits. Odd parity starts at 1.
  always_comb begin
    raw_par = {(NUM_CH*PAR_W){ODD_PARITY != 0}};
    for (int c = 0; c < NUM_CH; c++) begin
      for (int b = 0; b < DATA_W; b++) begin
        raw_par[c][b / GRAN_W] = raw_par[c][b / GRAN_W] ^ I_DATA[c*DATA_W + b];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      // Invalid channels contribute nothing downstream.
      assign gen_gated[gi] = I_VALID[gi] ? raw_par[gi] : '0;
      assign rcv_gated[gi] = I_VALID[gi] ? rcv_par[gi] : '0;

      // Injection flips syndrome bit 0 of channel 0, whether or not valid.
      if (gi == 0) begin : g_inj
        assign syn_s1_next[gi] =
          (valid_s1_reg[gi] ? (gen_s1_reg[gi] ^ rcv_s1_reg[gi]) : '0) ^ PAR_W'(inj_s1_reg);
      end else begin : g_noinj
        assign syn_s1_next[gi] =
          valid_s1_reg[gi] ? (gen_s1_reg[gi] ^ rcv_s1_reg[gi]) : '0;
      end

      assign mis[gi] = |syn_s2_reg[gi];
    end
  endgenerate

  assign O_GEN_PARITY = gen_gated;
  assign ev           = |mis;
  assign cnt_sat      = &cnt_reg;

  // Lowest-index mismatching channel wins the capture record.
  always_comb begin
    first_ch_next  = '0;
    first_syn_next = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (mis[c]) begin
        first_ch_next  = CH_IDX_W'(c);
        first_syn_next = syn_s2_reg[c];
      end
    end
  end

  // A new event on the clear cycle keeps the monitor latched.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_OK:      if (ev) state_next = ST_LATCHED;
      ST_LATCHED: if (I_CLR && !ev) state_next = ST_OK;
      default:    state_next = ST_OK;
    endcase
  end

  always_ff @(posedge ACLK or negedge RESETN_ACLK) begin
    if (!RESETN_ACLK) begin
      valid_s1_reg  <= '0;
      gen_s1_reg    <= '0;
      rcv_s1_reg    <= '0;
      fierr_q_reg   <= 1'b0;
      inj_s1_reg    <= 1'b0;
      syn_s2_reg    <= '0;
      state_reg     <= ST_OK;
      err_reg       <= 1'b0;
      err_b_reg     <= 1'b1;
      status_reg    <= '0;
      first_ch_reg  <= '0;
      first_syn_reg <= '0;
      cnt_reg       <= '0;
    end else begin
      valid_s1_reg <= I_VALID;
      gen_s1_reg   <= gen_gated;
      rcv_s1_reg   <= rcv_gated;
      fierr_q_reg  <= I_FIERR;
      inj_s1_reg   <= I_FIERR & ~fierr_q_reg;
      syn_s2_reg   <= syn_s1_next;

      state_reg <= state_next;
      err_reg   <= I_ENERR & (state_next == ST_LATCHED);
      err_b_reg <= ~(I_ENERR & (state_next == ST_LATCHED));

      status_reg <= I_CLR ? mis : (status_reg | mis);

      // A clear without an event loads the all-zero record.
      if (I_CLR || (state_reg == ST_OK && ev)) begin
        first_ch_reg  <= first_ch_next;
        first_syn_reg <= first_syn_next;
      end

      if (I_CLR) begin
        cnt_reg <= CNT_W'(ev);
      end else if (ev && !cnt_sat) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign O_ERR        = err_reg;
  assign O_ERR_B      = err_b_reg;
  assign O_ERR_STATUS = status_reg;
  assign O_FIRST_CH   = first_ch_reg;
  assign O_FIRST_SYN  = first_syn_reg;
  assign O_ERR_CNT    = cnt_reg;
  assign O_CNT_SAT    = cnt_sat;

endmodule

// File: tb/tb_parity_check_monitor.sv
// Bench for parity_check_monitor. Three instances share control inputs:
//   u_a : 4 ch x 64 bit, even parity, 8-bit counter
//   u_b : same data as u_a, 2-bit counter (saturation)
//   u_c : 1 ch x 5 bit, odd parity, single partial granule (PAR_W=1)
module tb_parity_check_monitor;

  localparam int NCH [3] = '{4, 4, 1};
  localparam int DW  [3] = '{64, 64, 5};
  localparam int GW  [3] = '{8, 8, 8};
  localparam int ODD [3] = '{0, 0, 1};
  localparam int CW  [3] = '{8, 2, 4};
  localparam int PW  [3] = '{8, 8, 1};

  logic         clk;
  logic         rst_n;
  logic [255:0] data0;
  logic [31:0]  par0;
  logic [3:0]   valid0;
  logic [4:0]   data2;
  logic [0:0]   par2;
  logic [0:0]   valid2;
  logic         enerr, fierr, clr;

  logic [31:0] gp0, gp1;
  logic [0:0]  gp2;
  logic        err0, errb0, sat0, err1, errb1, sat1, err2, errb2, sat2;
  logic [3:0]  st0, st1;
  logic [0:0]  st2;
  logic [1:0]  fch0, fch1;
  logic [0:0]  fch2;
  logic [7:0]  fsyn0, fsyn1;
  logic [0:0]  fsyn2;
  logic [7:0]  cnt0;
  logic [1:0]  cnt1;
  logic [3:0]  cnt2;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 0;

  // Behavioural model: a two-deep delay line of per-channel syndromes.
  logic [7:0] m_syn1 [3][4];
  logic [7:0] m_syn2 [3][4];
  logic [3:0] m_status [3];
  bit         m_lat [3];
  int         m_fch [3];
  logic [7:0] m_fsyn [3];
  int         m_cnt [3];
  bit         m_err [3];
  bit         m_fierr_prev;

  logic [63:0] a_gp [3], a_st [3], a_fch [3], a_fsyn [3], a_cnt [3];
  logic        a_err [3], a_errb [3], a_sat [3];

  parity_check_monitor #(.NUM_CH(4), .DATA_W(64), .GRAN_W(8), .ODD_PARITY(0),
                         .CNT_W(8), .CH_IDX_W(2)) u_a (
    .ACLK(clk), .RESETN_ACLK(rst_n), .I_DATA(data0), .I_PARITY(par0),
    .I_VALID(valid0), .I_ENERR(enerr), .I_FIERR(fierr), .I_CLR(clr),
    .O_GEN_PARITY(gp0), .O_ERR(err0), .O_ERR_B(errb0), .O_ERR_STATUS(st0),
    .O_FIRST_CH(fch0), .O_FIRST_SYN(fsyn0), .O_ERR_CNT(cnt0), .O_CNT_SAT(sat0));

  parity_check_monitor #(.NUM_CH(4), .DATA_W(64), .GRAN_W(8), .ODD_PARITY(0),
                         .CNT_W(2), .CH_IDX_W(2)) u_b (
    .ACLK(clk), .RESETN_ACLK(rst_n), .I_DATA(data0), .I_PARITY(par0),
    .I_VALID(valid0), .I_ENERR(enerr), .I_FIERR(fierr), .I_CLR(clr),
    .O_GEN_PARITY(gp1), .O_ERR(err1), .O_ERR_B(errb1), .O_ERR_STATUS(st1),
    .O_FIRST_CH(fch1), .O_FIRST_SYN(fsyn1), .O_ERR_CNT(cnt1), .O_CNT_SAT(sat1));

  parity_check_monitor #(.NUM_CH(1), .DATA_W(5), .GRAN_W(8), .ODD_PARITY(1),
                         .CNT_W(4), .CH_IDX_W(1)) u_c (
    .ACLK(clk), .RESETN_ACLK(rst_n), .I_DATA(data2), .I_PARITY(par2),
    .I_VALID(valid2), .I_ENERR(enerr), .I_FIERR(fierr), .I_CLR(clr),
    .O_GEN_PARITY(gp2), .O_ERR(err2), .O_ERR_B(errb2), .O_ERR_STATUS(st2),
    .O_FIRST_CH(fch2), .O_FIRST_SYN(fsyn2), .O_ERR_CNT(cnt2), .O_CNT_SAT(sat2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Parity of each granule counted directly from the ones in it.
  function automatic logic [7:0] gen_par(input logic [63:0] d, input int dw,
                                         input int gw, input int odd);
    logic [7:0]  p;
    logic [63:0] chunk;
    int          w;
    p = '0;
    for (int g = 0; g * gw < dw; g++) begin
      w = (dw - g * gw < gw) ? dw - g * gw : gw;
      chunk = (d >> (g * gw)) & ((64'd1 << w) - 64'd1);
      p[g] = (($countones(chunk) % 2) == 1) ^ (odd != 0);
    end
    return p;
  endfunction

  function automatic logic [63:0] in_data(input int k, input int c);
    return (k == 2) ? {59'd0, data2} : data0[c*64 +: 64];
  endfunction

  function automatic logic [7:0] in_par(input int k, input int c);
    return (k == 2) ? {7'd0, par2} : par0[c*8 +: 8];
  endfunction

  function automatic bit in_valid(input int k, input int c);
    return (k == 2) ? valid2[0] : valid0[c];
  endfunction

  function automatic logic [63:0] exp_gp(input int k);
    logic [63:0] r;
    logic [7:0]  g;
    r = '0;
    for (int c = 0; c < NCH[k]; c++) begin
      if (in_valid(k, c)) begin
        g = gen_par(in_data(k, c), DW[k], GW[k], ODD[k]);
        for (int j = 0; j < PW[k]; j++) r[c*PW[k] + j] = g[j];
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 4; c++) begin
        m_syn1[k][c] = '0;
        m_syn2[k][c] = '0;
      end
      m_status[k] = '0;
      m_lat[k]    = 0;
      m_fch[k]    = 0;
      m_fsyn[k]   = '0;
      m_cnt[k]    = 0;
      m_err[k]    = 0;
    end
    m_fierr_prev = 0;
  endtask

  // One clock edge of the model, using inputs as sampled at that edge.
  task automatic model_step();
    bit         inj, ev, nxt;
    int         low, maxc;
    logic [3:0] mis;
    inj = fierr && !m_fierr_prev;
    m_fierr_prev = fierr;
    for (int k = 0; k < 3; k++) begin
      mis = '0;
      low = -1;
      for (int c = 0; c < NCH[k]; c++) begin
        if (m_syn2[k][c] != 0) begin
          mis[c] = 1'b1;
          if (low < 0) low = c;
        end
      end
      ev  = (low >= 0);
      nxt = ev || (m_lat[k] && !clr);
      m_status[k] = clr ? mis : (m_status[k] | mis);
      if (clr || (!m_lat[k] && ev)) begin
        if (ev) begin
          m_fch[k]  = low;
          m_fsyn[k] = m_syn2[k][low];
        end else begin
          m_fch[k]  = 0;
          m_fsyn[k] = '0;
        end
      end
      maxc = (1 << CW[k]) - 1;
      if (clr) m_cnt[k] = ev ? 1 : 0;
      else if (ev && m_cnt[k] < maxc) m_cnt[k] = m_cnt[k] + 1;
      m_err[k] = enerr && nxt;
      m_lat[k] = nxt;
      for (int c = 0; c < 4; c++) m_syn2[k][c] = m_syn1[k][c];
      for (int c = 0; c < NCH[k]; c++) begin
        m_syn1[k][c] = in_valid(k, c) ?
          (in_par(k, c) ^ gen_par(in_data(k, c), DW[k], GW[k], ODD[k])) : 8'd0;
      end
      if (inj) m_syn1[k][0][0] = ~m_syn1[k][0][0];
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      a_gp[0] = 64'(gp0);  a_gp[1] = 64'(gp1);  a_gp[2] = 64'(gp2);
      a_st[0] = 64'(st0);  a_st[1] = 64'(st1);  a_st[2] = 64'(st2);
      a_fch[0] = 64'(fch0); a_fch[1] = 64'(fch1); a_fch[2] = 64'(fch2);
      a_fsyn[0] = 64'(fsyn0); a_fsyn[1] = 64'(fsyn1); a_fsyn[2] = 64'(fsyn2);
      a_cnt[0] = 64'(cnt0); a_cnt[1] = 64'(cnt1); a_cnt[2] = 64'(cnt2);
      a_err[0] = err0; a_err[1] = err1; a_err[2] = err2;
      a_errb[0] = errb0; a_errb[1] = errb1; a_errb[2] = errb2;
      a_sat[0] = sat0; a_sat[1] = sat1; a_sat[2] = sat2;
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("i%0d_gen_parity", k), a_gp[k], exp_gp(k));
        chk($sformatf("i%0d_err", k), 64'(a_err[k]), 64'(m_err[k]));
        chk($sformatf("i%0d_err_b", k), 64'(a_errb[k]), 64'(!m_err[k]));
        chk($sformatf("i%0d_status", k), a_st[k], 64'(m_status[k]));
        chk($sformatf("i%0d_first_ch", k), a_fch[k], 64'(m_fch[k]));
        chk($sformatf("i%0d_first_syn", k), a_fsyn[k], 64'(m_fsyn[k]));
        chk($sformatf("i%0d_cnt", k), a_cnt[k], 64'(m_cnt[k]));
        chk($sformatf("i%0d_cnt_sat", k), 64'(a_sat[k]),
            64'(m_cnt[k] == (1 << CW[k]) - 1));
      end
    end
  end

  // Advance one edge; inputs change 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    #1;
  endtask

  task automatic set_ch(input int c, input bit bad);
    logic [63:0] d;
    logic [7:0]  m;
    d = {$urandom, $urandom};
    m = bad ? 8'($urandom_range(1, 255)) : 8'd0;
    data0[c*64 +: 64] = d;
    par0[c*8 +: 8]    = gen_par(d, 64, 8, 0) ^ m;
    valid0[c]         = 1'b1;
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enerr = 1'b1; fierr = 1'b0; clr = 1'b0;
    data0 = '0; par0 = '0; valid0 = '0; data2 = '0; par2 = '0; valid2 = '0;
    model_reset();
    repeat (3) tick();
    #2 rst_n = 1'b1;
    cmp_en = 1;

    $display("[tb] reset state");
    chk("reset_err", 64'(err0), 64'd0);
    chk("reset_err_b", 64'(errb0), 64'd1);
    chk("reset_status", 64'(st0), 64'd0);
    chk("reset_cnt", 64'(cnt0), 64'd0);

    $display("[tb] ch2 good parity for 10 cycles");
    data0[2*64 +: 64] = 64'h1; par0[2*8 +: 8] = 8'h01; valid0 = 4'b0100;
    #1 chk("t1_gen_parity_ch2", 64'(gp0[23:16]), 64'h01);
    repeat (10) tick();
    chk("t1_no_err", 64'(err0), 64'd0);
    chk("t1_err_b", 64'(errb0), 64'd1);
    chk("t1_status", 64'(st0), 64'd0);

    $display("[tb] ch2 parity mismatch");
    par0[2*8 +: 8] = 8'h00;
    tick();
    valid0 = '0;
    tick(); tick();
    chk("t2_err", 64'(err0), 64'd1);
    chk("t2_err_b", 64'(errb0), 64'd0);
    chk("t2_status", 64'(st0), 64'b0100);
    chk("t2_first_ch", 64'(fch0), 64'd2);
    chk("t2_first_syn", 64'(fsyn0), 64'h01);
    chk("t2_cnt", 64'(cnt0), 64'd1);
    clr_pulse();
    chk("t2_clr_err", 64'(err0), 64'd0);
    chk("t2_clr_status", 64'(st0), 64'd0);
    chk("t2_clr_cnt", 64'(cnt0), 64'd0);

    $display("[tb] ch1+ch3 mismatch, then ch0");
    set_ch(1, 1); set_ch(3, 1);
    tick();
    valid0 = '0; set_ch(0, 1);
    tick();
    valid0 = '0;
    tick(); tick();
    chk("t3_first_ch", 64'(fch0), 64'd1);
    chk("t3_status", 64'(st0), 64'b1011);
    chk("t3_cnt", 64'(cnt0), 64'd2);
    clr_pulse();

    $display("[tb] bad parity on invalid channel");
    set_ch(2, 1); valid0 = '0;
    repeat (3) tick();
    chk("t4_invalid_err", 64'(err0), 64'd0);
    chk("t4_invalid_status", 64'(st0), 64'd0);

    $display("[tb] fault inject held 5 cycles");
    fierr = 1'b1;
    repeat (5) tick();
    fierr = 1'b0;
    repeat (3) tick();
    chk("t4_fi_status", 64'(st0), 64'b0001);
    chk("t4_fi_cnt", 64'(cnt0), 64'd1);
    chk("t4_fi_first_syn", 64'(fsyn0), 64'h01);
    chk("t4_fi_first_ch", 64'(fch0), 64'd0);
    clr_pulse();

    $display("[tb] five error cycles, counter saturation");
    repeat (5) begin
      set_ch(0, 1);
      tick();
      valid0 = '0;
    end
    tick(); tick();
    chk("t5_cnt2_value", 64'(cnt1), 64'd3);
    chk("t5_cnt2_sat", 64'(sat1), 64'd1);
    chk("t5_cnt8_value", 64'(cnt0), 64'd5);

    $display("[tb] clear alone");
    clr_pulse();
    chk("t5_clr_err", 64'(err0), 64'd0);
    chk("t5_clr_status", 64'(st0), 64'd0);
    chk("t5_clr_cnt2", 64'(cnt1), 64'd0);
    chk("t5_clr_sat2", 64'(sat1), 64'd0);

    $display("[tb] clear coincident with ch3 error");
    set_ch(0, 1);
    tick();
    valid0 = '0; set_ch(3, 1);
    tick();
    valid0 = '0;
    tick();
    chk("t5_pre_clr_err", 64'(err0), 64'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t5_coinc_status", 64'(st0), 64'b1000);
    chk("t5_coinc_cnt", 64'(cnt0), 64'd1);
    chk("t5_coinc_first_ch", 64'(fch0), 64'd3);
    chk("t5_coinc_err", 64'(err0), 64'd1);
    clr_pulse();

    $display("[tb] error with enable low, then raised");
    enerr = 1'b0;
    set_ch(1, 1);
    tick();
    valid0 = '0;
    tick(); tick();
    chk("t6_masked_err", 64'(err0), 64'd0);
    chk("t6_masked_err_b", 64'(errb0), 64'd1);
    chk("t6_masked_status", 64'(st0), 64'b0010);
    chk("t6_masked_cnt", 64'(cnt0), 64'd1);
    enerr = 1'b1;
    tick();
    chk("t6_raise_err", 64'(err0), 64'd1);
    chk("t6_raise_err_b", 64'(errb0), 64'd0);

    $display("[tb] asynchronous reset mid-error");
    set_ch(2, 1);
    tick();
    valid0 = '0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_err", 64'(err0), 64'd0);
    chk("t6_rst_err_b", 64'(errb0), 64'd1);
    chk("t6_rst_status", 64'(st0), 64'd0);
    chk("t6_rst_cnt", 64'(cnt0), 64'd0);
    chk("t6_rst_first_ch", 64'(fch0), 64'd0);
    chk("t6_rst_first_syn", 64'(fsyn0), 64'd0);
    tick();
    #2 rst_n = 1'b1;
    repeat (4) tick();
    chk("t6_inflight_err", 64'(err0), 64'd0);
    chk("t6_inflight_status", 64'(st0), 64'd0);

    $display("[tb] randomized traffic, 2000 cycles");
    for (int i = 0; i < 2000; i++) begin
      valid0 = 4'($urandom);
      for (int c = 0; c < 4; c++) begin
        data0[c*64 +: 64] = {$urandom, $urandom};
        par0[c*8 +: 8] = gen_par(data0[c*64 +: 64], 64, 8, 0) ^
                         (($urandom % 4 == 0) ? 8'($urandom_range(1, 255)) : 8'd0);
      end
      data2  = 5'($urandom);
      valid2 = 1'($urandom);
      par2   = 1'(gen_par({59'd0, data2}, 5, 8, 1)) ^ 1'($urandom % 4 == 0);
      clr    = ($urandom % 20 == 0);
      if ($urandom % 10 == 0) enerr = ~enerr;
      if ($urandom % 8 == 0) fierr = ~fierr;
      if (i == 1000) begin
        #2 rst_n = 1'b0;
        model_reset();
        #4 rst_n = 1'b1;
      end
      tick();
    end
    clr = 1'b0; valid0 = '0; valid2 = '0; fierr = 1'b0;
    repeat (4) tick();
    cmp_en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
